// File: rtl/approx_mul_pkg.sv
// Shared widths, types and constants for the 4x4 approximate multiplier.
// Optional error-magnitude output is enabled with macro APPROX_MUL_ERR_MON_EN.
package approx_mul_pkg;

    localparam int OP_W  = 4;
    localparam int RES_W = 8;
    localparam int BLK_W = 2;

    typedef logic [OP_W-1:0]  op_t;
    typedef logic [RES_W-1:0] res_t;

    // Value produced by an approximate 2x2 block for 3*3 (true value is 9).
    localparam logic [2:0] APPROX_33 = 3'd7;

    // Left-shift applied to the partial product of block idx.
    // Block order: 0=AL*BL, 1=AL*BH, 2=AH*BL, 3=AH*BH.
    function automatic int blk_shift(input int idx);
        return ((idx >> 1) + (idx & 1)) * BLK_W;
    endfunction

endpackage

// File: rtl/approx_mul_2x2.sv
// 2x2-bit multiplier block, exact or approximate (3*3 -> 7) by parameter.
module approx_mul_2x2
    import approx_mul_pkg::*;
#(
    parameter bit EXACT = 1'b0
) (
    input  logic [BLK_W-1:0] x,
    input  logic [BLK_W-1:0] y,
    output logic [3:0]       p
);

    logic [3:0] prod_full;

    assign prod_full = {2'b00, x} * {2'b00, y};

    generate
        if (EXACT) begin : g_exact
            assign p = prod_full;
        end else begin : g_approx
            // Only 3*3 overflows three bits; replace it so the block stays 3 bits wide.
            assign p = ((x == 2'd3) && (y == 2'd3)) ? {1'b0, APPROX_33} : prod_full;
        end
    endgenerate

endmodule

// File: rtl/approx_mul_4x4.sv
// Unsigned 4x4 approximate multiplier built from four 2x2 blocks, registered output.
// Optional macro APPROX_MUL_ERR_MON_EN adds err_mag = A*B - result, registered alongside.
module approx_mul_4x4
    import approx_mul_pkg::*;
#(
    parameter logic [3:0] EXACT_BLOCKS = 4'b0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic       out_valid,
    output logic [7:0] result
`ifdef APPROX_MUL_ERR_MON_EN
    ,
    output logic [7:0] err_mag
`endif
);

    logic [BLK_W-1:0] a_hi;
    logic [BLK_W-1:0] a_lo;
    logic [BLK_W-1:0] b_hi;
    logic [BLK_W-1:0] b_lo;

    logic [3:0] blk_p  [4];
    res_t       pp     [4];

    res_t product_next;
    res_t result_reg;
    logic valid_reg;

    assign a_hi = A[3:2];
    assign a_lo = A[1:0];
    assign b_hi = B[3:2];
    assign b_lo = B[1:0];

    // Block gi uses A half gi[1] and B half gi[0]; weight follows from the halves used.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_blk
            approx_mul_2x2 #(
                .EXACT (EXACT_BLOCKS[gi])
            ) u_blk (
                .x (((gi >> 1) != 0) ? a_hi : a_lo),
                .y (((gi & 1) != 0)  ? b_hi : b_lo),
                .p (blk_p[gi])
            );
            assign pp[gi] = res_t'(blk_p[gi]) << blk_shift(gi);
        end
    endgenerate

    // Exact full-width sum of the shifted partial products.
    always_comb begin
        product_next = pp[0] + pp[1] + pp[2] + pp[3];
    end

    // Output register: capture on in_valid, otherwise hold result and drop valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg  <= 1'b0;
            result_reg <= '0;
        end else begin
            valid_reg <= in_valid;
            if (in_valid) begin
                result_reg <= product_next;
            end
        end
    end

    assign out_valid = valid_reg;
    assign result    = result_reg;

`ifdef APPROX_MUL_ERR_MON_EN
    res_t err_next;
    res_t err_reg;

    // Approximation never overestimates, so the difference is non-negative.
    always_comb begin
        err_next = ({4'b0000, A} * {4'b0000, B}) - product_next;
    end

    // Error register tracks the result register's capture/hold behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= '0;
        end else if (in_valid) begin
            err_reg <= err_next;
        end
    end

    assign err_mag = err_reg;
`endif

endmodule

// File: tb/tb_approx_mul_4x4.sv
// Self-checking bench for approx_mul_4x4: default-mask and all-exact instances.
module tb_approx_mul_4x4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic [7:0] result;
    logic       out_valid_x;
    logic [7:0] result_x;
`ifdef APPROX_MUL_ERR_MON_EN
    logic [7:0] err_mag;
    logic [7:0] err_mag_x;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    approx_mul_4x4 #(.EXACT_BLOCKS(4'b0000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (a),
        .B         (b),
        .out_valid (out_valid),
        .result    (result)
`ifdef APPROX_MUL_ERR_MON_EN
        ,
        .err_mag   (err_mag)
`endif
    );

    approx_mul_4x4 #(.EXACT_BLOCKS(4'b1111)) dut_exact (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (a),
        .B         (b),
        .out_valid (out_valid_x),
        .result    (result_x)
`ifdef APPROX_MUL_ERR_MON_EN
        ,
        .err_mag   (err_mag_x)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: true product minus 2*weight for each non-exact block whose halves are both 3.
    function automatic int ref_p(input int av, input int bv, input logic [3:0] mask);
        int p;
        p = av * bv;
        if ((av % 4) == 3 && (bv % 4) == 3 && !mask[0]) p -= 2;
        if ((av % 4) == 3 && (bv / 4) == 3 && !mask[1]) p -= 8;
        if ((av / 4) == 3 && (bv % 4) == 3 && !mask[2]) p -= 8;
        if ((av / 4) == 3 && (bv / 4) == 3 && !mask[3]) p -= 32;
        return p;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; a = 4'd9; b = 4'd9;
        #1;
        n_checks++;
        if (result !== 8'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: result=%0d out_valid=%b, required 0/0", result, out_valid);
        end
        $display("reset: result=%0d out_valid=%b", result, out_valid);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a = 4'd5; b = 4'd6; in_valid = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (result !== 8'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: result=%0d out_valid=%b, required 0/0", result, out_valid);
        end
        $display("reset mid-stream: result=%0d out_valid=%b", result, out_valid);
        @(negedge clk);
        rst_n = 1'b1;
        a = 4'd3; b = 4'd3; in_valid = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_valid: out_valid=%b, required 0", out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (result !== 8'd7 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_3x3: result=%0d out_valid=%b, required 7/1", result, out_valid);
        end
        n_checks++;
        if (result_x !== 8'd9) begin
            n_fail++;
            $display("FAIL latency_3x3_exact: result=%0d, required 9", result_x);
        end
`ifdef APPROX_MUL_ERR_MON_EN
        n_checks++;
        if (err_mag !== 8'd2) begin
            n_fail++;
            $display("FAIL latency_3x3_err: err_mag=%0d, required 2", err_mag);
        end
`endif
        $display("3x3: result=%0d exact_inst=%0d", result, result_x);
    endtask

    task automatic test_directed();
        int ta [7] = '{2, 10, 0, 7, 13, 15, 5};
        int tb [7] = '{3, 10, 15, 7, 11, 15, 0};
        int te [7] = '{6, 100, 0, 47, 135, 175, 0};
        int tr [7] = '{0, 0, 0, 2, 8, 50, 0};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            a = 4'(ta[i]); b = 4'(tb[i]); in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            n_checks++;
            if (result !== 8'(te[i]) || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL directed %0dx%0d: result=%0d out_valid=%b, required %0d/1",
                         ta[i], tb[i], result, out_valid, te[i]);
            end
            n_checks++;
            if (result_x !== 8'(ta[i] * tb[i])) begin
                n_fail++;
                $display("FAIL directed_exact %0dx%0d: result=%0d, required %0d",
                         ta[i], tb[i], result_x, ta[i] * tb[i]);
            end
`ifdef APPROX_MUL_ERR_MON_EN
            n_checks++;
            if (err_mag !== 8'(tr[i])) begin
                n_fail++;
                $display("FAIL directed_err %0dx%0d: err_mag=%0d, required %0d",
                         ta[i], tb[i], err_mag, tr[i]);
            end
`else
            if (tr[i] < 0) $display("unexpected table entry");
`endif
            $display("directed %0dx%0d: result=%0d exact_inst=%0d", ta[i], tb[i], result, result_x);
        end
    endtask

    task automatic test_back_to_back_sweep();
        int pa, pb, exp_p;
        real rel_sum;
        int nz;
        pa = 0; pb = 0; rel_sum = 0.0; nz = 0;
        for (int i = 0; i <= 256; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp_p = ref_p(pa, pb, 4'b0000);
                n_checks++;
                if (result !== 8'(exp_p) || out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sweep %0dx%0d: result=%0d out_valid=%b, required %0d/1",
                             pa, pb, result, out_valid, exp_p);
                end
                n_checks++;
                if (int'(result) > pa * pb) begin
                    n_fail++;
                    $display("FAIL sweep_bound %0dx%0d: result=%0d, required <= %0d",
                             pa, pb, result, pa * pb);
                end
                n_checks++;
                if (result_x !== 8'(pa * pb) || out_valid_x !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sweep_exact %0dx%0d: result=%0d out_valid=%b, required %0d/1",
                             pa, pb, result_x, out_valid_x, pa * pb);
                end
`ifdef APPROX_MUL_ERR_MON_EN
                n_checks++;
                if (err_mag !== 8'(pa * pb - exp_p)) begin
                    n_fail++;
                    $display("FAIL sweep_err %0dx%0d: err_mag=%0d, required %0d",
                             pa, pb, err_mag, pa * pb - exp_p);
                end
`endif
                if (pa * pb != 0) begin
                    rel_sum += real'(pa * pb - int'(result)) / real'(pa * pb);
                    nz++;
                end
                $display("sweep %0dx%0d: result=%0d exact_inst=%0d", pa, pb, result, result_x);
            end
            if (i < 256) begin
                a = 4'(i >> 4); b = 4'(i); in_valid = 1'b1;
                pa = i >> 4; pb = i & 15;
            end else begin
                in_valid = 1'b0;
            end
        end
        $display("mean relative error over %0d nonzero products: %f", nz, rel_sum / real'(nz));
    endtask

    task automatic test_hold();
        @(negedge clk);
        a = 4'd7; b = 4'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; a = 'x; b = 'x;
        n_checks++;
        if (result !== 8'd47 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_load: result=%0d out_valid=%b, required 47/1", result, out_valid);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a = 4'(15 - k); b = 4'(k + 4);
            n_checks++;
            if (result !== 8'd47 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: result=%0d out_valid=%b, required 47/0",
                         k, result, out_valid);
            end
`ifdef APPROX_MUL_ERR_MON_EN
            n_checks++;
            if (err_mag !== 8'd2) begin
                n_fail++;
                $display("FAIL hold_err%0d: err_mag=%0d, required 2", k, err_mag);
            end
`endif
            $display("hold %0d: result=%0d out_valid=%b", k, result, out_valid);
        end
    endtask

    task automatic test_random();
        int exp_r, exp_rx, exp_e;
        logic exp_v;
        int av, bv;
        exp_r = 47; exp_rx = 49; exp_e = 2; exp_v = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n_checks++;
            if (result !== 8'(exp_r) || out_valid !== exp_v) begin
                n_fail++;
                $display("FAIL random%0d: result=%0d out_valid=%b, required %0d/%b",
                         i, result, out_valid, exp_r, exp_v);
            end
            n_checks++;
            if (result_x !== 8'(exp_rx)) begin
                n_fail++;
                $display("FAIL random_exact%0d: result=%0d, required %0d", i, result_x, exp_rx);
            end
`ifdef APPROX_MUL_ERR_MON_EN
            n_checks++;
            if (err_mag !== 8'(exp_e)) begin
                n_fail++;
                $display("FAIL random_err%0d: err_mag=%0d, required %0d", i, err_mag, exp_e);
            end
`endif
            $display("random %0d: result=%0d out_valid=%b", i, result, out_valid);
            av = int'($urandom_range(0, 15));
            bv = int'($urandom_range(0, 15));
            a = 4'(av); b = 4'(bv);
            in_valid = ($urandom_range(0, 3) != 0);
            exp_v = in_valid;
            if (in_valid) begin
                exp_r  = ref_p(av, bv, 4'b0000);
                exp_rx = av * bv;
                exp_e  = av * bv - exp_r;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_directed();
        test_back_to_back_sweep();
        test_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/approx_mul_4x4.md
Name: approx_mul_4x4

Overview:
- Unsigned 4x4-bit approximate multiplier for error-tolerant datapaths.
- Built from four 2x2 partial-product blocks. The only approximation is in each 2x2 block: 3x3 yields 7 instead of 9.
- Partial products are summed exactly. The output is registered with one cycle of latency.
- Used as a low-area replacement for an exact multiplier; error is characterised by mean relative error over all 256 operand pairs.

Parameters:
- EXACT_BLOCKS, 4'b0000, per-block exact-mode mask. Bit0 = AL*BL, bit1 = AL*BH, bit2 = AH*BL, bit3 = AH*BH. A set bit makes that 2x2 block exact.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid this cycle
- A  in  4  unsigned multiplicand
- B  in  4  unsigned multiplier
- out_valid  out  1  result valid
- result  out  8  unsigned approximate product

Behaviour:
- One clock; reset is asynchronous and active-low. While rst_n=0: result=8'd0, out_valid=0, applied immediately without waiting for a clock edge.
- Operand split: AH=A[3:2], AL=A[1:0], BH=B[3:2], BL=B[1:0].
- 2x2 block m(x,y), approximate mode:
  - Output is 3 bits, equal to x*y exactly for every input pair except x=3,y=3.
  - For x=3,y=3 the output is 3'b111 (7).
- 2x2 block, exact mode: 4-bit output, 3x3=9.
- Product: P = (m(AH,BH)<<4) + (m(AH,BL)<<2) + (m(AL,BH)<<2) + m(AL,BL).
  - Summed at full width; no truncation.
  - Maximum value 175 in all-approximate mode, so P always fits in 8 bits.
- Approximation only ever underestimates: P <= A*B for all inputs.
- Latency:
  - On each rising clk edge with in_valid=1: result <= P(A,B) and out_valid <= 1.
  - On each rising clk edge with in_valid=0: out_valid <= 0 and result holds its previous value.
- Back-to-back: one new operand pair accepted per cycle; no stall and no backpressure.
- Reset mid-operation: the pending result is discarded; out_valid=0 on the first cycle after release.
- A=0 or B=0 gives result 0.
- Unknown/X operands with in_valid=0 do not affect result.

Optional Feature:
- Macro APPROX_MUL_ERR_MON_EN.
- When defined:
  - Adds output err_mag [7:0], registered alongside result, equal to A*B - P (always >= 0).
  - err_mag resets to 0 and holds when in_valid=0.
- When undefined: the port and all logic for it are absent; the core is otherwise identical.

Decomposition:
- Package approx_mul_pkg holds:
  - constants OP_W=4, RES_W=8, BLK_W=2
  - typedefs op_t (logic [3:0]) and res_t (logic [7:0])
  - constant APPROX_33 = 3'd7
- One natural sub-module, approx_mul_2x2.
  - Inputs: x[1:0], y[1:0], and a parameter EXACT.
  - Output: p[3:0].
  - Instantiated four times, with EXACT taken from the matching bit of EXACT_BLOCKS.
- Top level holds the shifted-add tree and the output registers.

Test Plan:
- Reset and latency: assert rst_n=0 mid-stream -> result=0 and out_valid=0 immediately. Release, drive A=3,B=3,in_valid=1 -> one cycle later result=7, out_valid=1 (exact would be 9).
- Exact paths, default mask: A=2,B=3 -> 6; A=10,B=10 -> 100; A=0,B=15 -> 0.
- Approximation paths, default mask:
  - A=7,B=7 -> 47.
  - A=13,B=11 -> 135.
  - A=15,B=15 -> 175.
  - With APPROX_MUL_ERR_MON_EN, err_mag = 2, 8 and 50 respectively.
- Exhaustive sweep, all 256 pairs one per cycle:
  - result matches the golden model and result <= A*B throughout.
  - Mean relative error over nonzero products is reported.
  - Back-to-back in_valid=1 keeps out_valid=1 continuously.
- Hold behaviour: drop in_valid after A=7,B=7, then change A,B -> result stays 47 and out_valid=0.
- EXACT_BLOCKS=4'b1111: full sweep -> result equals A*B for all pairs (15x15 -> 225).
